// File: rtl/adi_dma_split_pkg.sv
// rtl/adi_dma_split_pkg.sv - shared constants and state encoding for the DMA packet splitter
package adi_dma_split_pkg;

  // cmd bit positions
  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;

  // status bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_SHORT   = 2;
  localparam int ST_PKTS_LO = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adi_dma_split_skid.sv
// rtl/adi_dma_split_skid.sv - two-entry stream skid buffer with synchronous flush
//  clk, rst, flush                 : clock, sync active-high reset, sync flush
//  s_tdata/s_tvalid/s_tready       : upstream side
//  m_tdata/m_tvalid/m_tready       : downstream side (registered)
//  empty                           : nothing held in either entry
module adi_dma_split_skid #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         empty
);

  logic [W-1:0] skid_tdata;
  logic         skid_tvalid;
  logic         push;
  logic         pop;

  // The skid entry only fills while the output entry is stalled, so a free
  // skid slot is enough to guarantee room for one more beat.
  assign s_tready = ~skid_tvalid;
  assign empty    = ~m_tvalid & ~skid_tvalid;
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      skid_tvalid <= 1'b0;
      skid_tdata  <= '0;
    end else if (!m_tvalid || pop) begin
      // Output slot frees up: the older skid beat goes first to keep order.
      if (skid_tvalid) begin
        m_tdata     <= skid_tdata;
        m_tvalid    <= 1'b1;
        skid_tvalid <= 1'b0;
      end else begin
        m_tvalid <= push;
        if (push) m_tdata <= s_tdata;
      end
    end else if (push) begin
      skid_tdata  <= s_tdata;
      skid_tvalid <= 1'b1;
    end
  end

endmodule

// File: rtl/adi_dma_split.sv
// rtl/adi_dma_split.sv - re-cuts one long DMA stream into num_pkts packets of pkt_len beats
//  AXIS_ACLK, AXIS_ARESET         : clock, sync active-high reset
//  S_AXIS_*                       : long input stream from DMA
//  M_AXIS_*                       : packetised output with regenerated TLAST
//  cmd                            : [0] start (rising edge), [1] abort (level)
//  num_pkts, pkt_len              : run shape, latched on start
//  status                         : [0] busy, [1] done, [2] short_pkt, [31:16] pkts_sent
module adi_dma_split
  import adi_dma_split_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESET,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,
  input  logic [31:0]       cmd,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic [31:0]       status
);

  state_t             state;
  logic               start_q;
  logic [CNT_W-1:0]   num_l;
  logic [LEN_W-1:0]   len_l;
  logic [LEN_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   in_pkts;
  logic [CNT_W-1:0]   pkts_sent;
  logic               done_r;
  logic               short_r;

  logic               start_edge;
  logic               abort;
  logic               run;
  logic               s_hs;
  logic               m_hs;
  logic               at_boundary;
  logic               cut;
  logic               last_pkt;
  logic               skid_s_tready;
  logic               skid_empty;
  logic [DATA_W:0]    skid_m_tdata;
  logic               unused_cmd;

  assign unused_cmd  = ^cmd[31:2];

  assign start_edge  = cmd[CMD_START] & ~start_q;
  assign abort       = cmd[CMD_ABORT];
  assign run         = (state == RUN);

  assign S_AXIS_TREADY = run & skid_s_tready;
  assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_hs          = M_AXIS_TVALID & M_AXIS_TREADY;

  // Packet closes on the length boundary or on an upstream TLAST, whichever
  // comes first; beats past the boundary never exist because the boundary cuts.
  assign at_boundary = (beat_cnt == len_l - LEN_W'(1));
  assign cut         = at_boundary | S_AXIS_TLAST;
  // num_l == 0 means run forever, so never report the final packet.
  assign last_pkt    = (num_l != '0) && ((in_pkts + CNT_W'(1)) == num_l);

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      num_l     <= '0;
      len_l     <= '0;
      beat_cnt  <= '0;
      in_pkts   <= '0;
      pkts_sent <= '0;
      done_r    <= 1'b0;
      short_r   <= 1'b0;
    end else begin
      start_q <= cmd[CMD_START];

      if (m_hs && M_AXIS_TLAST) pkts_sent <= pkts_sent + CNT_W'(1);

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_edge) begin
              state     <= RUN;
              num_l     <= num_pkts;
              len_l     <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
              beat_cnt  <= '0;
              in_pkts   <= '0;
              pkts_sent <= '0;
              done_r    <= 1'b0;
              short_r   <= 1'b0;
            end
          end
          RUN: begin
            if (s_hs) begin
              beat_cnt <= cut ? '0 : beat_cnt + LEN_W'(1);
              if (S_AXIS_TLAST && !at_boundary) short_r <= 1'b1;
              if (cut) begin
                in_pkts <= in_pkts + CNT_W'(1);
                if (last_pkt) state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (skid_empty) begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  adi_dma_split_skid #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk      (AXIS_ACLK),
    .rst      (AXIS_ARESET),
    .flush    (abort),
    .s_tdata  ({cut, S_AXIS_TDATA}),
    .s_tvalid (S_AXIS_TVALID & run),
    .s_tready (skid_s_tready),
    .m_tdata  (skid_m_tdata),
    .m_tvalid (M_AXIS_TVALID),
    .m_tready (M_AXIS_TREADY),
    .empty    (skid_empty)
  );

  assign M_AXIS_TDATA = skid_m_tdata[DATA_W-1:0];
  assign M_AXIS_TLAST = skid_m_tdata[DATA_W];

  assign status = {pkts_sent[15:0], 13'd0, short_r, done_r,
                   (state == RUN) || (state == DRAIN)};

endmodule

// File: tb/tb_adi_dma_split.sv
// tb/tb_adi_dma_split.sv - randomized self-checking bench for adi_dma_split
module tb_adi_dma_split;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [31:0] cmd;
  logic [31:0] num_pkts;
  logic [15:0] pkt_len;
  logic [31:0] status;

  int n_checks = 0;
  int n_errors = 0;

  logic [64:0] exp_q[$];
  logic [63:0] sd_q[$];
  logic        sl_q[$];
  int          m_mode = 0;
  logic        gaps = 1'b0;
  logic        exp_short;

  logic        held = 1'b0;
  logic [64:0] held_val;

  always #5 clk = ~clk;

  adi_dma_split dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .cmd           (cmd),
    .num_pkts      (num_pkts),
    .pkt_len       (pkt_len),
    .status        (status)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream ready pattern: 0 always high, 1 toggling, 2 random
  always @(posedge clk) begin
    #1;
    case (m_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(1));
    endcase
  end

  // Output monitor: every M handshake must match the next expected beat,
  // and a stalled beat must not change.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && m_tvalid) check("m_stable", {m_tlast, m_tdata}, held_val);
      held = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("m_extra_beat", m_tvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("m_beat", {m_tlast, m_tdata}, e);
        end
      end else if (m_tvalid) begin
        held     = 1'b1;
        held_val = {m_tlast, m_tdata};
      end
    end
  end

  // Reference: walk packets of len (0 -> 1) beats; an upstream TLAST closes
  // a packet early and marks it short unless it lands on the boundary.
  task automatic build(input int len, input int num, input int tl_pct, input int force_idx);
    int len_eff;
    int idx;
    int pos;
    logic tl;
    logic last;
    logic [63:0] d;
    len_eff   = (len == 0) ? 1 : len;
    idx       = 0;
    exp_short = 1'b0;
    for (int p = 0; p < num; p++) begin
      pos = 0;
      do begin
        d    = {32'($urandom()), 32'(idx)};
        tl   = (idx == force_idx) || (int'($urandom_range(99)) < tl_pct);
        last = tl || (pos == len_eff - 1);
        if (tl && pos != len_eff - 1) exp_short = 1'b1;
        sd_q.push_back(d);
        sl_q.push_back(tl);
        exp_q.push_back({last, d});
        idx++;
        pos++;
      end while (!last);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic l);
    int n;
    if (gaps) begin
      while ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) check("s_accept_timeout", s_tready, 1'b1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic start_run(input int len, input int num);
    pkt_len  = 16'(len);
    num_pkts = 32'(num);
    cmd      = 32'h1;
    @(posedge clk); #1;
    cmd      = 32'h0;
    check("start_status", status, 32'h0000_0001);
  endtask

  task automatic wait_done(input int num);
    int n;
    n = 0;
    while (!status[1] && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done", status[1], 1'b1);
    check("busy_after_done", status[0], 1'b0);
    check("short_pkt", status[2], exp_short);
    check("pkts_sent", status[31:16], 16'(num));
    check("s_tready_after_done", s_tready, 1'b0);
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic run_case(input int len, input int num_dut, input int num_model,
                          input int tl_pct, input int force_idx, input int mode, input logic gap_on);
    sd_q.delete();
    sl_q.delete();
    build(len, num_model, tl_pct, force_idx);
    m_mode = mode;
    gaps   = gap_on;
    start_run(len, num_dut);
    while (sd_q.size() != 0) drive_beat(sd_q.pop_front(), sl_q.pop_front());
    if (num_dut != 0) wait_done(num_dut);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int r_len;
    int r_num;
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    cmd      = '0;
    num_pkts = '0;
    pkt_len  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_tready", s_tready, 1'b0);
    check("reset_m_tvalid", m_tvalid, 1'b0);
    check("reset_status", status, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 12-beat ramp, 3 packets of 4, ready held high
    run_case(4, 3, 3, 0, -1, 0, 1'b0);
    // same shape with toggling downstream ready
    run_case(4, 3, 3, 0, -1, 1, 1'b0);
    // early upstream TLAST on beat 5 of an 8-beat packet
    run_case(8, 2, 2, 0, 5, 0, 1'b0);
    // zero length behaves as one-beat packets
    run_case(0, 2, 2, 0, -1, 0, 1'b0);

    // unlimited run then abort
    run_case(2, 0, 50, 0, -1, 0, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("unlimited_pkts_sent", status[31:16], 16'd50);
    check("unlimited_busy", status[0], 1'b1);
    cmd = 32'h2;
    @(posedge clk); #1;
    cmd = 32'h0;
    check("abort_busy", status[0], 1'b0);
    check("abort_done", status[1], 1'b0);
    check("abort_m_tvalid", m_tvalid, 1'b0);
    check("abort_s_tready", s_tready, 1'b0);

    // reset in the middle of a packet
    m_mode = 0;
    gaps   = 1'b0;
    start_run(4, 1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 64'(i + 100)});
      drive_beat(64'(i + 100), 1'b0);
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_s_tready", s_tready, 1'b0);
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_m_tlast", m_tlast, 1'b0);
    check("midrst_m_tdata", m_tdata, 64'h0);
    check("midrst_status", status, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_case(4, 2, 2, 0, -1, 2, 1'b1);

    // randomized shapes, early TLASTs, random stalls and gaps
    for (int k = 0; k < 6; k++) begin
      r_len = int'($urandom_range(6));
      r_num = int'($urandom_range(4, 1));
      run_case(r_len, r_num, r_num, 15, -1, 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
